// File: rtl/sampled_check_arbiter_pkg.sv
// Shared types for the sampled-value check arbiter: FSM states, result record, index width helper.
// Types only, so no latency or backpressure applies here.
package sampled_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FAIL = 2'd2,
    DONE = 2'd3
  } state_e;

  // Result ids are carried at a fixed width so the record does not depend on N_REQ.
  localparam int MAX_ID_W = 8;

  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
    logic                pass;
  } chk_result_t;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sampled_check_arbiter_if.sv
// Requester-side bundle of the check arbiter: request/data/expectation in, grant and result out.
// No backpressure: a grant is combinational, and its result arrives one cycle later.
interface sampled_check_arbiter_if
  import sampled_chk_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = 8
);
  localparam int ID_W = id_w(N_REQ);

  logic                 start;
  logic [N_REQ-1:0]     req;
  logic [N_REQ*W-1:0]   req_data;
  logic [N_REQ-1:0]     req_chg;
  logic [N_REQ-1:0]     gnt;
  logic                 chk_valid;
  logic [ID_W-1:0]      chk_id;
  logic                 chk_pass;
  logic                 fail;
  logic                 done;
  logic [31:0]          cyc;

  modport master (
    output start, req, req_data, req_chg,
    input  gnt, chk_valid, chk_id, chk_pass, fail, done, cyc
  );

  modport slave (
    input  start, req, req_data, req_chg,
    output gnt, chk_valid, chk_id, chk_pass, fail, done, cyc
  );

endinterface

// File: rtl/sampled_check_arbiter_rr_arbiter.sv
// Round-robin picker: first eligible index scanning up from ptr, wrapping modulo N.
// Purely combinational; zero latency and no backpressure.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = sampled_chk_pkg::id_w(N)
) (
  input  logic [N-1:0]  elig,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idx = IW'((int'(ptr) + k) % N);
      if (!found && elig[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = idx;
      end
    end
  end

endmodule

// File: rtl/sampled_check_arbiter.sv
// Shares one sampled-value comparator among N_REQ requesters round-robin and sequences the run.
// Result is registered one cycle after grant; no backpressure, ungranted requesters simply wait.
module sampled_check_arbiter
  import sampled_chk_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int W       = 8,
  parameter int MAX_CYC = 11
) (
  input  logic                   clk,
  input  logic                   rst,
  sampled_check_arbiter_if.slave bus
);

  localparam int ID_W = id_w(N_REQ);

  state_e           state;
  logic [W-1:0]     samp     [N_REQ];
  logic [W-1:0]     data_a   [N_REQ];
  logic [N_REQ-1:0] samp_vld;
  logic [ID_W-1:0]  ptr;
  logic [31:0]      cyc_q;
  chk_result_t      res_q;

  logic [N_REQ-1:0] elig;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_idx;
  logic             gnt_any;
  logic             cmp_pass;
  logic             unused_id_hi;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign data_a[i] = bus.req_data[i*W +: W];
  end

  // A requester is only comparable once its previous-edge value has been captured.
  assign elig    = (state == RUN) ? (bus.req & samp_vld) : '0;
  assign gnt_any = |gnt;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (ID_W)
  ) u_rr (
    .elig    (elig),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    cmp_pass = 1'b0;
    if (bus.req_chg[gnt_idx])
      cmp_pass = (data_a[gnt_idx] != samp[gnt_idx]);
    else
      cmp_pass = (data_a[gnt_idx] == samp[gnt_idx]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      samp_vld <= '0;
      cyc_q    <= '0;
      res_q    <= '0;
      for (int i = 0; i < N_REQ; i++)
        samp[i] <= '0;
    end else begin
      res_q.valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state <= RUN;
            cyc_q <= '0;
          end
        end
        RUN: begin
          cyc_q    <= cyc_q + 32'd1;
          samp_vld <= '1;
          for (int i = 0; i < N_REQ; i++)
            samp[i] <= data_a[i];
          if (gnt_any) begin
            res_q.valid <= 1'b1;
            res_q.id    <= MAX_ID_W'(gnt_idx);
            res_q.pass  <= cmp_pass;
            ptr         <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          end
          // A failing check on the final edge still reports FAIL rather than DONE.
          if (gnt_any && !cmp_pass)
            state <= FAIL;
          else if (cyc_q == 32'(MAX_CYC - 1))
            state <= DONE;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.gnt       = gnt;
  assign bus.chk_valid = res_q.valid;
  assign bus.chk_id    = res_q.id[ID_W-1:0];
  assign bus.chk_pass  = res_q.pass;
  assign bus.fail      = (state == FAIL);
  assign bus.done      = (state == DONE);
  assign bus.cyc       = cyc_q;
  assign unused_id_hi  = ^res_q.id;

  gnt_onehot_a: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));

endmodule

// File: tb/tb_sampled_check_arbiter.sv
// Directed bench for sampled_check_arbiter: reset, priming, round-robin, wrap/skip, fail, fail-vs-done.
module tb_sampled_check_arbiter;

  localparam int N_REQ   = 4;
  localparam int W       = 8;
  localparam int MAX_CYC = 11;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_mis = 0;

  // Per-cycle expectations for the round-robin / wrap-and-skip run (index = cyc).
  int gnt_tab [11] = '{0, 1, 2, 4, 8, 1, 2, 4, 1, 4, 1};
  int id_tab  [11] = '{0, 0, 0, 1, 2, 3, 0, 1, 2, 0, 2};

  sampled_check_arbiter_if #(.N_REQ(N_REQ), .W(W)) bus ();

  sampled_check_arbiter #(
    .N_REQ   (N_REQ),
    .W       (W),
    .MAX_CYC (MAX_CYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus.start    = 1'b0;
    bus.req      = '0;
    bus.req_chg  = '0;
    bus.req_data = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // ---- Reset state, then reset in the middle of a run ----
    do_reset();
    check_eq("rst_gnt", 32'(bus.gnt), 0);
    check_eq("rst_chk_valid", 32'(bus.chk_valid), 0);
    check_eq("rst_chk_id", 32'(bus.chk_id), 0);
    check_eq("rst_chk_pass", 32'(bus.chk_pass), 0);
    check_eq("rst_fail", 32'(bus.fail), 0);
    check_eq("rst_done", 32'(bus.done), 0);
    check_eq("rst_cyc", bus.cyc, 0);

    bus.req = 4'b1111;
    do_start();
    repeat (5) step();
    check_eq("mid_cyc5", bus.cyc, 5);
    rst = 1'b1;
    settle();
    check_eq("mid_rst_cyc", bus.cyc, 0);
    check_eq("mid_rst_gnt", 32'(bus.gnt), 0);
    check_eq("mid_rst_chk_valid", 32'(bus.chk_valid), 0);
    check_eq("mid_rst_fail", 32'(bus.fail), 0);
    check_eq("mid_rst_done", 32'(bus.done), 0);
    rst = 1'b0;
    step();
    check_eq("post_rst_idle_cyc", bus.cyc, 0);
    check_eq("post_rst_idle_gnt", 32'(bus.gnt), 0);

    // ---- Priming: single toggling requester expecting change ----
    do_reset();
    bus.req      = 4'b0001;
    bus.req_chg  = 4'b0001;
    bus.req_data = '0;
    do_start();
    settle();
    check_eq("prime_unprimed_gnt", 32'(bus.gnt), 0);
    check_eq("prime_cyc0", bus.cyc, 0);
    for (int k = 1; k < MAX_CYC; k++) begin
      step();
      check_eq("prime_cyc", bus.cyc, 32'(k));
      check_eq("prime_chk_valid", 32'(bus.chk_valid), 32'(k >= 2));
      if (k >= 2) begin
        check_eq("prime_chk_pass", 32'(bus.chk_pass), 1);
        check_eq("prime_chk_id", 32'(bus.chk_id), 0);
      end
      bus.req_data = 32'(k % 2);
      settle();
      check_eq("prime_gnt", 32'(bus.gnt), 1);
    end
    step();
    check_eq("prime_done", 32'(bus.done), 1);
    check_eq("prime_done_fail", 32'(bus.fail), 0);
    check_eq("prime_done_cyc", bus.cyc, MAX_CYC);
    check_eq("prime_last_valid", 32'(bus.chk_valid), 1);
    check_eq("prime_last_pass", 32'(bus.chk_pass), 1);
    settle();
    check_eq("prime_done_gnt", 32'(bus.gnt), 0);
    step();
    check_eq("prime_after_valid", 32'(bus.chk_valid), 0);
    check_eq("prime_frozen_cyc", bus.cyc, MAX_CYC);
    check_eq("prime_sticky_done", 32'(bus.done), 1);

    // ---- Round-robin over all four, then wrap-and-skip with req=0101 ----
    do_reset();
    bus.req      = 4'b1111;
    bus.req_chg  = 4'b0000;
    bus.req_data = 32'h4433_2211;
    do_start();
    settle();
    check_eq("rr_unprimed_gnt", 32'(bus.gnt), 0);
    for (int c = 1; c < MAX_CYC; c++) begin
      step();
      check_eq("rr_cyc", bus.cyc, 32'(c));
      if (c >= 2) begin
        check_eq("rr_chk_valid", 32'(bus.chk_valid), 1);
        check_eq("rr_chk_id", 32'(bus.chk_id), 32'(id_tab[c]));
        check_eq("rr_chk_pass", 32'(bus.chk_pass), 1);
      end
      if (c == 8) bus.req = 4'b0101;
      settle();
      check_eq("rr_gnt", 32'(bus.gnt), 32'(gnt_tab[c]));
    end
    step();
    check_eq("rr_done", 32'(bus.done), 1);
    check_eq("rr_last_id", 32'(bus.chk_id), 0);
    check_eq("rr_last_pass", 32'(bus.chk_pass), 1);
    settle();
    check_eq("rr_done_gnt", 32'(bus.gnt), 0);

    // ---- Failure: requester 2 held at A5 but expecting change ----
    do_reset();
    bus.req      = 4'b0100;
    bus.req_chg  = 4'b0100;
    bus.req_data = 32'h00A5_0000;
    do_start();
    settle();
    check_eq("fail_unprimed_gnt", 32'(bus.gnt), 0);
    step();
    settle();
    check_eq("fail_gnt", 32'(bus.gnt), 4);
    step();
    check_eq("fail_chk_valid", 32'(bus.chk_valid), 1);
    check_eq("fail_chk_id", 32'(bus.chk_id), 2);
    check_eq("fail_chk_pass", 32'(bus.chk_pass), 0);
    check_eq("fail_flag", 32'(bus.fail), 1);
    check_eq("fail_no_done", 32'(bus.done), 0);
    check_eq("fail_cyc", bus.cyc, 2);
    settle();
    check_eq("fail_gnt_off", 32'(bus.gnt), 0);
    repeat (3) step();
    check_eq("fail_cyc_frozen", bus.cyc, 2);
    check_eq("fail_valid_low", 32'(bus.chk_valid), 0);
    check_eq("fail_id_hold", 32'(bus.chk_id), 2);
    check_eq("fail_pass_hold", 32'(bus.chk_pass), 0);
    check_eq("fail_sticky", 32'(bus.fail), 1);
    check_eq("fail_gnt_frozen", 32'(bus.gnt), 0);

    // ---- Failing check granted on the last RUN cycle: FAIL beats DONE ----
    do_reset();
    bus.req      = 4'b0000;
    bus.req_chg  = 4'b0100;
    bus.req_data = 32'h00A5_0000;
    do_start();
    repeat (MAX_CYC - 1) step();
    check_eq("sim_cyc_pre", bus.cyc, MAX_CYC - 1);
    bus.req = 4'b0100;
    settle();
    check_eq("sim_gnt", 32'(bus.gnt), 4);
    step();
    check_eq("sim_fail", 32'(bus.fail), 1);
    check_eq("sim_done", 32'(bus.done), 0);
    check_eq("sim_chk_pass", 32'(bus.chk_pass), 0);
    check_eq("sim_chk_id", 32'(bus.chk_id), 2);
    check_eq("sim_cyc", bus.cyc, MAX_CYC);
    step();
    check_eq("sim_fail_sticky", 32'(bus.fail), 1);
    check_eq("sim_done_low", 32'(bus.done), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
